// File: rtl/ddr_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr_wr_pkg
// Brief    : Shared types and constants for the DDR burst writer.
// Revision : 1.0
// ============================================================================
package ddr_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_t;

    localparam int SKID_DEPTH = 8;
    localparam int SKID_AW    = 3;

    // First word address past the ring region; hitting it wraps to the base.
    function automatic longint ring_end(input longint base, input longint words);
        return base + words;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_wr_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ddr_wr_skid_fifo
// Brief    : Small synchronous show-ahead FIFO absorbing read latency and
//            Avalon back-pressure between the sample FIFO and DDR.
// Revision : 1.0
// ============================================================================
module ddr_wr_skid_fifo
    import ddr_wr_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic [SKID_AW:0]  o_level,
    output logic              o_empty
);

    localparam logic [SKID_AW:0] c_full_level = (SKID_AW + 1)'(SKID_DEPTH);

    logic [DATA_W-1:0]  r_mem [SKID_DEPTH];
    logic [SKID_AW-1:0] r_wr_ptr;
    logic [SKID_AW-1:0] r_rd_ptr;
    logic [SKID_AW:0]   r_level;
    logic               w_full;

    assign w_full  = (r_level == c_full_level);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_head  = r_mem[r_rd_ptr];

    // Storage is left unreset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + SKID_AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + SKID_AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + (SKID_AW + 1)'(1);
                2'b01:   r_level <= r_level - (SKID_AW + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && !i_pop && w_full));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(i_pop && o_empty));

endmodule
`default_nettype wire

// File: rtl/ddr_burst_writer.sv
`default_nettype none
// ============================================================================
// Module   : ddr_burst_writer
// Brief    : Drains the sample FIFO into DDR as fixed-length Avalon-MM write
//            bursts over a ring-buffer address region.
// Revision : 1.0
// ============================================================================
module ddr_burst_writer
    import ddr_wr_pkg::*;
#(
    parameter int BURST_LEN  = 64,
    parameter int ADDR_W     = 25,
    parameter int BASE_ADDR  = 0,
    parameter int RING_WORDS = 1048576,
    parameter int USEDW_W    = 11,
    parameter int RD_LAT     = 2
) (
    input  logic               ddr_clk,
    input  logic               reset_syn,
    input  logic               enable,
    input  logic [USEDW_W-1:0] fifo_rdusedw,
    input  logic               fifo_full,
    input  logic [31:0]        fifo_data,
    output logic               rd_fifo_req,
    output logic [ADDR_W-1:0]  avl_addr,
    output logic [31:0]        avl_wdata,
    output logic               avl_write,
    output logic               avl_burstbegin,
    output logic [7:0]         avl_size,
    input  logic               avl_ready,
    output logic [31:0]        burst_cnt,
    output logic               ovf,
    output logic               busy
);

    localparam int                 c_cnt_w      = $clog2(BURST_LEN) + 1;
    localparam logic [c_cnt_w-1:0] c_last_beat  = c_cnt_w'(BURST_LEN - 1);
    localparam logic [USEDW_W:0]   c_usedw_min  = (USEDW_W + 1)'(BURST_LEN);
    localparam logic [ADDR_W:0]    c_burst_step = (ADDR_W + 1)'(BURST_LEN);
    localparam logic [ADDR_W-1:0]  c_base       = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]    c_ring_end   =
        (ADDR_W + 1)'(ring_end(longint'(BASE_ADDR), longint'(RING_WORDS)));

    wr_state_t          r_state;
    logic [c_cnt_w-1:0] r_req_cnt;
    logic [c_cnt_w-1:0] r_beat_cnt;
    logic [RD_LAT-1:0]  r_vld_sr;
    logic               r_rd_req;
    logic               r_first;
    logic               r_ovf;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_burst_cnt;

    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_head;
    logic [SKID_AW:0]   w_level;
    logic               w_empty;
    logic               w_start;
    logic               w_req_next;
    logic [ADDR_W:0]    w_addr_inc;
    int                 w_inflight_n;
    int                 w_level_n;
    int                 w_req_cnt_n;

    ddr_wr_skid_fifo #(
        .DATA_W (32)
    ) u_skid (
        .clk     (ddr_clk),
        .rst     (reset_syn),
        .i_push  (w_push),
        .i_din   (fifo_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_level (w_level),
        .o_empty (w_empty)
    );

    assign w_push     = r_vld_sr[RD_LAT-1];
    assign avl_write  = (r_state == ST_BURST) && !w_empty;
    assign w_pop      = avl_write && avl_ready;
    assign w_start    = enable && ({1'b0, fifo_rdusedw} >= c_usedw_min);
    assign w_addr_inc = {1'b0, r_addr} + c_burst_step;

    // rd_fifo_req is registered, so the decision looks at next-cycle occupancy:
    // skid level after this edge plus everything still in the read pipeline.
    always_comb begin
        w_inflight_n = $countones(r_vld_sr) - int'(r_vld_sr[RD_LAT-1]) + int'(r_rd_req);
        w_level_n    = int'(w_level) + int'(w_push) - int'(w_pop);
        w_req_cnt_n  = int'(r_req_cnt) + int'(r_rd_req);
        w_req_next   = ((r_state == ST_BURST) || ((r_state == ST_IDLE) && w_start))
                       && (w_req_cnt_n < BURST_LEN)
                       && (w_level_n + w_inflight_n <= SKID_DEPTH - 1);
    end

    always_ff @(posedge ddr_clk) begin
        if (reset_syn) begin
            r_state     <= ST_IDLE;
            r_req_cnt   <= '0;
            r_beat_cnt  <= '0;
            r_vld_sr    <= '0;
            r_rd_req    <= 1'b0;
            r_first     <= 1'b0;
            r_ovf       <= 1'b0;
            r_addr      <= c_base;
            r_burst_cnt <= '0;
        end else begin
            r_ovf    <= r_ovf | fifo_full;
            r_vld_sr <= (r_vld_sr << 1) | RD_LAT'(r_rd_req);
            r_rd_req <= w_req_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state    <= ST_BURST;
                        r_first    <= 1'b1;
                        r_beat_cnt <= '0;
                    end
                end
                ST_BURST: begin
                    r_req_cnt <= c_cnt_w'(w_req_cnt_n);
                    if (w_pop) begin
                        r_first    <= 1'b0;
                        r_beat_cnt <= r_beat_cnt + c_cnt_w'(1);
                        if (r_beat_cnt == c_last_beat) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_burst_cnt <= r_burst_cnt + 32'd1;
                    r_addr      <= (w_addr_inc == c_ring_end) ? c_base : w_addr_inc[ADDR_W-1:0];
                    r_req_cnt   <= '0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rd_fifo_req    = r_rd_req;
    assign avl_addr       = r_addr;
    assign avl_wdata      = avl_write ? w_head : 32'd0;
    assign avl_burstbegin = avl_write && r_first;
    assign avl_size       = 8'(BURST_LEN);
    assign burst_cnt      = r_burst_cnt;
    assign ovf            = r_ovf;
    assign busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ddr_burst_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_burst_writer
// Brief    : Randomized self-checking bench for ddr_burst_writer.
// Revision : 1.0
// ============================================================================
module tb_ddr_burst_writer;
    import ddr_wr_pkg::*;

    localparam int BURST_LEN  = 64;
    localparam int ADDR_W     = 25;
    localparam int BASE_ADDR  = 256;
    localparam int RING_WORDS = 128;
    localparam int USEDW_W    = 11;
    localparam int RD_LAT     = 2;

    logic               ddr_clk = 1'b0;
    logic               reset_syn;
    logic               enable;
    logic [USEDW_W-1:0] fifo_rdusedw;
    logic               fifo_full;
    logic [31:0]        fifo_data;
    logic               rd_fifo_req;
    logic [ADDR_W-1:0]  avl_addr;
    logic [31:0]        avl_wdata;
    logic               avl_write;
    logic               avl_burstbegin;
    logic [7:0]         avl_size;
    logic               avl_ready;
    logic [31:0]        burst_cnt;
    logic               ovf;
    logic               busy;

    always #5 ddr_clk = ~ddr_clk;

    ddr_burst_writer #(
        .BURST_LEN  (BURST_LEN),
        .ADDR_W     (ADDR_W),
        .BASE_ADDR  (BASE_ADDR),
        .RING_WORDS (RING_WORDS),
        .USEDW_W    (USEDW_W),
        .RD_LAT     (RD_LAT)
    ) dut (
        .ddr_clk        (ddr_clk),
        .reset_syn      (reset_syn),
        .enable         (enable),
        .fifo_rdusedw   (fifo_rdusedw),
        .fifo_full      (fifo_full),
        .fifo_data      (fifo_data),
        .rd_fifo_req    (rd_fifo_req),
        .avl_addr       (avl_addr),
        .avl_wdata      (avl_wdata),
        .avl_write      (avl_write),
        .avl_burstbegin (avl_burstbegin),
        .avl_size       (avl_size),
        .avl_ready      (avl_ready),
        .burst_cnt      (burst_cnt),
        .ovf            (ovf),
        .busy           (busy)
    );

    // Reference model state: sample FIFO as an endless ramp, expected beats as a queue.
    int                n_chk = 0;
    int                n_err = 0;
    logic [31:0]       next_word = 32'd0;
    logic [31:0]       req_word;
    bit                req_seen = 1'b0;
    logic [31:0]       pipe [RD_LAT];
    logic [31:0]       exp_q [$];
    int                model_bursts = 0;
    int                beat_in_burst = 0;
    int                cyc = 0;
    int                first_cyc = 0;
    int                last_span = 0;
    int                busy_start_cyc = 0;
    int                max_out = 0;
    int                idle_req_err = 0;
    int                req_total = 0;
    int                ready_mode = 0;
    bit                prev_busy = 1'b0;
    bit                hold_valid = 1'b0;
    bit                hold_bb = 1'b0;
    logic [31:0]       hold_data = 32'd0;
    logic [ADDR_W-1:0] exp_addr = ADDR_W'(BASE_ADDR);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic monitor();
        logic [31:0] w;
        cyc++;
        req_seen = rd_fifo_req;
        if (rd_fifo_req) begin
            if (!busy) idle_req_err++;
            req_word = next_word;
            exp_q.push_back(next_word);
            next_word = next_word + 32'd1;
            req_total++;
        end
        if (reset_syn) begin
            exp_q.delete();
            model_bursts  = 0;
            beat_in_burst = 0;
            hold_valid    = 1'b0;
            prev_busy     = 1'b0;
            exp_addr      = ADDR_W'(BASE_ADDR);
            return;
        end
        if (busy && !prev_busy) busy_start_cyc = cyc;
        prev_busy = busy;
        if (exp_q.size() > max_out) max_out = exp_q.size();
        if (hold_valid) begin
            chk("hold_write", avl_write, 1);
            chk("hold_wdata", avl_wdata, hold_data);
            chk("hold_bb", avl_burstbegin, hold_bb);
        end
        hold_valid = avl_write && !avl_ready;
        hold_data  = avl_wdata;
        hold_bb    = avl_burstbegin;
        if (avl_write && avl_ready) begin
            if (beat_in_burst == 0) begin
                chk("bb_first", avl_burstbegin, 1);
                chk("first_beat_latency_ok", (cyc - busy_start_cyc) >= RD_LAT + 1, 1);
                first_cyc = cyc;
            end else begin
                chk("bb_mid", avl_burstbegin, 0);
            end
            chk("addr", avl_addr, exp_addr);
            if (exp_q.size() == 0) begin
                chk("underrun", 1, 0);
            end else begin
                w = exp_q.pop_front();
                chk("wdata", avl_wdata, w);
            end
            beat_in_burst++;
            if (beat_in_burst == BURST_LEN) begin
                beat_in_burst = 0;
                model_bursts++;
                last_span = cyc - first_cyc + 1;
                exp_addr  = ADDR_W'(BASE_ADDR + (model_bursts * BURST_LEN) % RING_WORDS);
            end
        end
    endtask

    task automatic drive_cycle();
        for (int i = RD_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0]   = req_seen ? req_word : $urandom();
        fifo_data = pipe[RD_LAT-1];
        case (ready_mode)
            0:       avl_ready = 1'b1;
            1:       avl_ready = ~avl_ready;
            default: avl_ready = ($urandom_range(0, 99) < 65);
        endcase
    endtask

    task automatic tick();
        @(negedge ddr_clk);
        monitor();
        @(posedge ddr_clk);
        #1;
        drive_cycle();
    endtask

    task automatic wait_busy(input logic val, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (busy === val) return;
            tick();
        end
        chk("timeout_busy", busy, val);
    endtask

    task automatic wait_beat(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (beat_in_burst == n) return;
            tick();
        end
        chk("timeout_beat", beat_in_burst, n);
    endtask

    task automatic run_one_burst(input int mode);
        ready_mode   = mode;
        enable       = 1'b1;
        fifo_rdusedw = USEDW_W'($urandom_range(BURST_LEN, 2047));
        wait_busy(1'b1, 20);
        fifo_rdusedw = USEDW_W'($urandom_range(0, BURST_LEN - 1));
        wait_busy(1'b0, 2000);
        chk("burst_cnt", burst_cnt, model_bursts);
    endtask

    initial begin
        int b0;
        int r0;
        reset_syn    = 1'b1;
        enable       = 1'b0;
        fifo_rdusedw = '0;
        fifo_full    = 1'b0;
        fifo_data    = 32'd0;
        avl_ready    = 1'b1;
        for (int i = 0; i < RD_LAT; i++) pipe[i] = 32'd0;

        repeat (3) tick();
        chk("rst_write", avl_write, 0);
        chk("rst_req", rd_fifo_req, 0);
        chk("rst_addr", avl_addr, BASE_ADDR);
        chk("rst_size", avl_size, BURST_LEN);
        chk("rst_burst_cnt", burst_cnt, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bb", avl_burstbegin, 0);
        chk("rst_wdata", avl_wdata, 0);
        reset_syn = 1'b0;

        // One word short of a burst: nothing may start.
        enable       = 1'b1;
        fifo_rdusedw = USEDW_W'(BURST_LEN - 1);
        repeat (20) tick();
        chk("below_fill_reqs", req_total, 0);
        chk("below_fill_busy", busy, 0);

        run_one_burst(0);
        chk("b1_reqs", req_total, BURST_LEN);
        chk("b1_span_full_rate", last_span, BURST_LEN);
        chk("b1_addr_next", avl_addr, BASE_ADDR + BURST_LEN);

        run_one_burst(1);
        chk("b2_addr_wrapped", avl_addr, BASE_ADDR);
        run_one_burst(2);
        chk("b3_addr_next", avl_addr, BASE_ADDR + BURST_LEN);
        chk("b3_count", burst_cnt, 3);

        // Back-to-back random bursts with a single fifo_full pulse.
        b0           = model_bursts;
        ready_mode   = 2;
        enable       = 1'b1;
        fifo_rdusedw = USEDW_W'($urandom_range(BURST_LEN, 2047));
        for (int i = 0; i < 4000 && model_bursts < b0 + 4; i++) begin
            fifo_full = (i == 37);
            tick();
        end
        fifo_full = 1'b0;
        enable    = 1'b0;
        wait_busy(1'b0, 50);
        chk("b2b_count", burst_cnt, b0 + 4);
        chk("ovf_sticky", ovf, 1);
        run_one_burst(0);
        chk("ovf_still_set", ovf, 1);

        // enable dropped mid-burst: burst completes, then stays idle.
        b0           = model_bursts;
        ready_mode   = 2;
        enable       = 1'b1;
        fifo_rdusedw = USEDW_W'(200);
        wait_busy(1'b1, 20);
        r0 = req_total;
        wait_beat(10, 500);
        enable = 1'b0;
        wait_busy(1'b0, 500);
        chk("edrop_count", burst_cnt, b0 + 1);
        chk("edrop_full_burst", beat_in_burst, 0);
        repeat (20) tick();
        chk("edrop_idle", busy, 0);
        chk("edrop_reqs", req_total - r0, BURST_LEN);

        // Reset in the middle of a burst.
        enable       = 1'b1;
        fifo_rdusedw = USEDW_W'(200);
        ready_mode   = 2;
        wait_beat(30, 500);
        reset_syn = 1'b1;
        tick();
        chk("mrst_write", avl_write, 0);
        chk("mrst_req", rd_fifo_req, 0);
        chk("mrst_addr", avl_addr, BASE_ADDR);
        chk("mrst_burst_cnt", burst_cnt, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ovf", ovf, 0);
        reset_syn = 1'b0;
        enable    = 1'b0;
        run_one_burst(2);
        chk("post_rst_count", burst_cnt, 1);
        chk("post_rst_addr", avl_addr, BASE_ADDR + BURST_LEN);

        chk("max_outstanding_le_depth", max_out <= SKID_DEPTH, 1);
        chk("no_req_while_idle", idle_req_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end

endmodule
`default_nettype wire
